// File: rtl/clock_div_multi.sv
// Multi-channel programmable clock divider with shadowed divisor loads and
// optional global phase realign (enabled by defining CLKDIV_SYNC_EN).
module clock_div_multi #(
    parameter int N_CH    = 4,
    parameter int DIV_W   = 16,
    parameter int RST_DIV = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [N_CH-1:0]       i_en,
    input  logic [N_CH*DIV_W-1:0] i_divisor,
    input  logic [N_CH-1:0]       i_load,
    input  logic                  i_sync,
    output logic [N_CH-1:0]       o_slow_clk,
    output logic [N_CH-1:0]       o_tick,
    output logic [N_CH-1:0]       o_pending
);

    localparam logic [DIV_W-1:0] RST_D   = DIV_W'(RST_DIV);
    localparam logic [DIV_W-1:0] D_ONE   = DIV_W'(1);
    localparam logic [DIV_W-1:0] D_TWO   = DIV_W'(2);
    localparam logic [DIV_W-2:0] CNT_ONE = (DIV_W-1)'(1);

    logic sync_hit;

`ifdef CLKDIV_SYNC_EN
    assign sync_hit = i_sync;
`else
    logic unused_sync;
    assign unused_sync = i_sync;
    assign sync_hit    = 1'b0;
`endif

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [DIV_W-1:0] d;
        logic [DIV_W-1:0] shadow;
        logic [DIV_W-1:0] slice;
        logic [DIV_W-1:0] low_len;
        logic [DIV_W-1:0] high_len;
        logic [DIV_W-1:0] next_d;
        logic [DIV_W-2:0] count;
        logic             level;
        logic             pending;
        logic             tick;
        logic             en_q;
        logic             bypass;
        logic             at_rise;
        logic             at_boundary;

        // count runs within one phase, so DIV_W-1 bits cover ceil(D/2)-1
        assign slice       = i_divisor[c*DIV_W +: DIV_W];
        assign bypass      = d < D_TWO;
        assign high_len    = d >> 1;
        assign low_len     = high_len + {{(DIV_W-1){1'b0}}, d[0]};
        assign at_rise     = !bypass && !level && ({1'b0, count} == low_len - D_ONE);
        assign at_boundary = !bypass &&  level && ({1'b0, count} == high_len - D_ONE);
        assign next_d      = i_load[c] ? slice : (pending ? shadow : d);

        // NOTE: all channel state is sequential, so every assignment below is
        // non-blocking; mixing in blocking writes would make the branch order
        // leak into same-cycle reads of d/shadow/pending.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                d       <= RST_D;
                shadow  <= RST_D;
                count   <= '0;
                level   <= 1'b0;
                pending <= 1'b0;
                tick    <= 1'b0;
                en_q    <= 1'b0;
            end else begin
                en_q <= i_en[c];
                if (!i_en[c] || sync_hit) begin
                    // disable or realign: restart low phase and apply any new divisor now
                    count   <= '0;
                    level   <= 1'b0;
                    tick    <= i_en[c] && (next_d < D_TWO);
                    d       <= next_d;
                    pending <= 1'b0;
                    if (i_load[c]) shadow <= slice;
                end else if (i_load[c] && at_boundary) begin
                    d       <= slice;
                    shadow  <= slice;
                    pending <= 1'b0;
                    count   <= '0;
                    level   <= 1'b0;
                    tick    <= slice < D_TWO;
                end else if (pending && (at_boundary || bypass)) begin
                    d       <= shadow;
                    count   <= '0;
                    level   <= 1'b0;
                    tick    <= shadow < D_TWO;
                    pending <= i_load[c];
                    if (i_load[c]) shadow <= slice;
                end else begin
                    if (i_load[c]) begin
                        shadow  <= slice;
                        pending <= 1'b1;
                    end
                    if (bypass) begin
                        count <= '0;
                        level <= 1'b0;
                        tick  <= 1'b1;
                    end else if (at_rise) begin
                        count <= '0;
                        level <= 1'b1;
                        tick  <= 1'b1;
                    end else if (at_boundary) begin
                        count <= '0;
                        level <= 1'b0;
                        tick  <= 1'b0;
                    end else begin
                        count <= count + CNT_ONE;
                        tick  <= 1'b0;
                    end
                end
            end
        end

        // bypass passes the source clock through, gated by the registered enable
        assign o_slow_clk[c] = bypass ? (i_clk & en_q) : level;
        assign o_tick[c]     = tick;
        assign o_pending[c]  = pending;
    end

endmodule

// File: doc/clock_div_multi.md
CLOCK_DIV_MULTI -- requirements
Module: clock_div_multi

Interface
REQ-001 Parameter N_CH, default 4: number of independent divider channels, range 1..16.
REQ-002 Parameter DIV_W, default 16: divisor width per channel, range 2..32.
REQ-003 Parameter RST_DIV, default 2: active divisor loaded into every channel at reset.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 i_clk  input  1: source clock; all state updates on its rising edge.
REQ-006 i_rst  input  1: synchronous active-high reset.
REQ-007 i_en  input  N_CH: per-channel enable, bit c controls channel c.
REQ-008 i_divisor  input  N_CH*DIV_W: new divisor per channel, slice [c*DIV_W +: DIV_W].
REQ-009 i_load  input  N_CH: per-channel one-cycle strobe that captures the i_divisor slice into the shadow register.
REQ-010 i_sync  input  1: global phase-realign strobe, functional only with CLKDIV_SYNC_EN.
REQ-011 o_slow_clk  output  N_CH: divided clock per channel.
REQ-012 o_tick  output  N_CH: one-cycle pulse, registered, high in the cycle o_slow_clk[c] goes 0->1.
REQ-013 o_pending  output  N_CH: high while a shadow divisor awaits application.

Function
REQ-014 Each channel holds count (DIV_W-1 bits), level, active divisor D, shadow divisor and pending flag.
REQ-015 D>=2, even: level low D/2 cycles, high D/2 cycles.
REQ-016 D>=2, odd: level low ceil(D/2) cycles, high floor(D/2) cycles; period D cycles.
REQ-017 D>=2: o_slow_clk[c] equals registered level; o_tick[c] is high exactly one cycle per period.
REQ-018 D=0 or D=1 (bypass): o_slow_clk[c] = i_clk AND registered enable; o_tick[c] high every cycle; count held 0.
REQ-019 Period boundary: the cycle in which level toggles 1->0, with count reset to 0.
REQ-020 i_load[c]=1: shadow <= slice; pending <= 1 next cycle.
REQ-021 Pending and boundary: D <= shadow, count <= 0, pending <= 0; the new timing starts with the low phase.
REQ-022 Pending and D<2: shadow applied on the next clock; level <= 0, count <= 0.
REQ-023 i_load[c] coinciding with a boundary: the new i_divisor slice is applied at that boundary directly; pending stays 0.
REQ-024 i_en[c]=0: count <= 0, level <= 0, o_tick[c] <= 0, o_slow_clk[c]=0; any pending shadow is applied immediately.
REQ-025 i_en[c] 0->1: the low phase starts on the first enabled cycle, with the first o_tick after ceil(D/2) cycles.
REQ-026 Per-channel priority: i_rst > i_en=0 > i_sync > shadow application > counting.
REQ-027 Channels are fully independent except for i_sync and i_rst.

Reset
REQ-028 i_rst=1 at a rising edge: every channel gets count=0, level=0, D=RST_DIV, shadow=RST_DIV, pending=0, o_tick=0.
REQ-029 While in reset: o_slow_clk=0 for D>=2; the registered enable is 0, so the bypass output is also 0.
REQ-030 Reset mid-period discards the partial period and any pending load.

Configuration
REQ-031 Macro CLKDIV_SYNC_EN defined: an i_sync pulse in cycle N forces count=0 and level=0 for every enabled channel, and applies pending shadows, all in cycle N+1; channels with D>=2 restart phase-aligned.
REQ-032 Macro CLKDIV_SYNC_EN absent: the i_sync port exists but is ignored, and no sync logic is synthesised.

Verification
REQ-033 N_CH=4, D={2,3,4,7} loaded after reset, all enabled -> periods 2/3/4/7 cycles; high times 1/1/2/3; one o_tick per period.
REQ-034 Ch0 D=4 running; i_load with 10 mid-high-phase -> o_pending=1; old period completes; first 10-cycle period starts at the boundary; o_pending=0.
REQ-035 Ch1 D=1 -> o_slow_clk[1] tracks i_clk and o_tick[1] is constant 1; loading 6 -> 6-cycle period starts the next clock.
REQ-036 Ch2 D=5 with i_en dropped mid-period -> output 0 next cycle; re-enable -> first o_tick after 3 cycles.
REQ-037 CLKDIV_SYNC_EN defined, D={4,6,8,3}, i_sync pulse -> all count=0, level=0 next cycle; rising edges coincide every 24 cycles. Macro absent -> i_sync has no effect.
REQ-038 i_rst asserted mid-period with a pending load -> all outputs 0; D=RST_DIV; o_pending=0; the first o_tick occurs 1 cycle after release (RST_DIV=2).
